// File: rtl/aes_framer_pkg.sv
// Shared types and constants for the UART-to-AES command framer.
package aes_framer_pkg;

  localparam int unsigned BLOCK_BYTES = 16;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned BLOCK_W     = BLOCK_BYTES * BYTE_W;
  localparam int unsigned CNT_W       = $clog2(BLOCK_BYTES);

  localparam logic [BYTE_W-1:0] STAT_ACK = 8'h06;
  localparam logic [BYTE_W-1:0] STAT_NAK = 8'h15;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_KEY,
    LOAD_PT,
    KEY_INIT,
    KEY_WAIT,
    ENC_START,
    ENC_WAIT,
    SEND_CT,
    SEND_STAT
  } state_t;

endpackage

// File: rtl/aes_framer_timeout.sv
// Inter-byte timeout counter: clears on request, counts while enabled, flags expiry.
module aes_framer_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CW = 32;

  logic [CW-1:0] cnt;

  // Saturates at the limit; a zero limit never expires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired_c) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired_c = (TIMEOUT_CYCLES != 0) && (cnt >= CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/aes_uart_framer.sv
// Byte-stream command framer: parses K/E frames from UART RX, drives the AES core,
// and returns ciphertext or a status byte on UART TX.
module aes_uart_framer
  import aes_framer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  CMD_KEY        = 8'h4B,
  parameter logic [7:0]  CMD_ENC        = 8'h45
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  output logic [7:0]   m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         aes_init,
  output logic         aes_next,
  input  logic         aes_ready,
  output logic [127:0] aes_key,
  output logic [127:0] aes_block,
  input  logic [127:0] aes_result,
  input  logic         aes_result_valid,
  output logic         busy
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               key_valid;
  logic               err;
  logic               first;
  logic [BLOCK_W-1:0] shadow;
  logic [BLOCK_W-1:0] ct_sr;

  logic rx_fire_c;
  logic tx_fire_c;
  logic loading_c;
  logic to_expired_c;

  assign rx_fire_c = s_axis_tvalid && s_axis_tready;
  assign tx_fire_c = m_axis_tvalid && m_axis_tready;
  assign loading_c = (state == LOAD_KEY) || (state == LOAD_PT);

  aes_framer_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr      (!loading_c || rx_fire_c),
    .en       (loading_c && !rx_fire_c),
    .expired_c(to_expired_c)
  );

  // Payload bytes shift in LSB-first; the word is committed to the core only when complete,
  // so a timed-out partial frame never disturbs aes_key/aes_block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      key_valid     <= 1'b0;
      err           <= 1'b0;
      first         <= 1'b0;
      shadow        <= '0;
      ct_sr         <= '0;
      aes_key       <= '0;
      aes_block     <= '0;
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      aes_init      <= 1'b0;
      aes_next      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      aes_init <= 1'b0;
      aes_next <= 1'b0;

      case (state)
        IDLE: begin
          s_axis_tready <= 1'b1;
          busy          <= 1'b0;
          if (rx_fire_c) begin
            cnt  <= '0;
            busy <= 1'b1;
            if (s_axis_tdata == CMD_KEY) begin
              state <= LOAD_KEY;
            end else if (s_axis_tdata == CMD_ENC) begin
              state <= LOAD_PT;
              err   <= !key_valid;
            end else begin
              state         <= SEND_STAT;
              s_axis_tready <= 1'b0;
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= STAT_NAK;
            end
          end
        end

        LOAD_KEY, LOAD_PT: begin
          if (rx_fire_c) begin
            shadow <= {s_axis_tdata, shadow[BLOCK_W-1:BYTE_W]};
            cnt    <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(BLOCK_BYTES - 1)) begin
              s_axis_tready <= 1'b0;
              if (state == LOAD_KEY) begin
                aes_key <= {s_axis_tdata, shadow[BLOCK_W-1:BYTE_W]};
                state   <= KEY_INIT;
              end else begin
                aes_block <= {s_axis_tdata, shadow[BLOCK_W-1:BYTE_W]};
                if (err) begin
                  state         <= SEND_STAT;
                  m_axis_tvalid <= 1'b1;
                  m_axis_tdata  <= STAT_NAK;
                end else begin
                  state <= ENC_START;
                end
              end
            end
          end else if (to_expired_c) begin
            state         <= SEND_STAT;
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= STAT_NAK;
          end
        end

        KEY_INIT: begin
          if (aes_ready) begin
            aes_init  <= 1'b1;
            key_valid <= 1'b0;
            first     <= 1'b1;
            state     <= KEY_WAIT;
          end
        end

        // The core's ready lags the start pulse by a cycle, so the first cycle is skipped.
        KEY_WAIT: begin
          if (first) begin
            first <= 1'b0;
          end else if (aes_ready) begin
            key_valid     <= 1'b1;
            state         <= SEND_STAT;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= STAT_ACK;
          end
        end

        ENC_START: begin
          if (aes_ready) begin
            aes_next <= 1'b1;
            first    <= 1'b1;
            state    <= ENC_WAIT;
          end
        end

        ENC_WAIT: begin
          if (first) begin
            first <= 1'b0;
          end else if (aes_ready && aes_result_valid) begin
            ct_sr         <= aes_result >> BYTE_W;
            m_axis_tdata  <= aes_result[BYTE_W-1:0];
            m_axis_tvalid <= 1'b1;
            cnt           <= '0;
            state         <= SEND_CT;
          end
        end

        SEND_CT: begin
          if (tx_fire_c) begin
            if (cnt == CNT_W'(BLOCK_BYTES - 1)) begin
              m_axis_tvalid <= 1'b0;
              s_axis_tready <= 1'b1;
              busy          <= 1'b0;
              state         <= IDLE;
            end else begin
              cnt          <= cnt + CNT_W'(1);
              m_axis_tdata <= ct_sr[BYTE_W-1:0];
              ct_sr        <= ct_sr >> BYTE_W;
            end
          end
        end

        SEND_STAT: begin
          if (tx_fire_c) begin
            m_axis_tvalid <= 1'b0;
            s_axis_tready <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end

        default: begin
          state         <= IDLE;
          m_axis_tvalid <= 1'b0;
          s_axis_tready <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_uart_framer.sv
// Directed bench for aes_uart_framer with a small behavioural AES core stand-in.
module tb_aes_uart_framer;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   s_axis_tdata = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic [7:0]   m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  logic         aes_init;
  logic         aes_next;
  logic         aes_ready = 1'b1;
  logic [127:0] aes_key;
  logic [127:0] aes_block;
  logic [127:0] aes_result = '0;
  logic         aes_result_valid = 1'b0;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  int init_cnt = 0;
  int next_cnt = 0;

  aes_uart_framer #(
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .aes_init        (aes_init),
    .aes_next        (aes_next),
    .aes_ready       (aes_ready),
    .aes_key         (aes_key),
    .aes_block       (aes_block),
    .aes_result      (aes_result),
    .aes_result_valid(aes_result_valid),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Core stand-in: goes busy for a few cycles after each start pulse; the ciphertext
  // is only correct if the plaintext presented at the pulse is the expected block.
  int  core_dly = 0;
  logic core_ct = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      aes_ready        = 1'b1;
      aes_result_valid = 1'b0;
      core_dly         = 0;
    end else if (aes_init || aes_next) begin
      if (aes_init) init_cnt++;
      if (aes_next) begin
        next_cnt++;
        aes_result = (aes_block == PT) ? CT : ~CT;
      end
      core_ct          = aes_next;
      aes_ready        = 1'b0;
      aes_result_valid = 1'b0;
      core_dly         = 4;
    end else if (core_dly > 0) begin
      core_dly--;
      if (core_dly == 0) begin
        aes_ready        = 1'b1;
        aes_result_valid = core_ct;
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called and returns at a negedge; byte transfers at the intervening posedge.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!s_axis_tready) chk("rx_accept_wait", 128'(s_axis_tready), 128'(1));
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b, output logic ok);
    int t;
    t = 0;
    m_axis_tready = 1'b1;
    while (!m_axis_tvalid && t < 300) begin
      @(negedge clk);
      t++;
    end
    ok = m_axis_tvalid;
    b  = m_axis_tdata;
    if (ok) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]   cmd;
    logic         has_payload;
    logic [127:0] payload;
    int           n_tx;
    logic [127:0] exp_tx;
    int           exp_init;
    int           exp_next;
  } vec_t;

  vec_t vecs[4];

  logic [7:0]   rb;
  logic         rok;
  logic [7:0]   hold;
  logic         stable;
  logic         rdy_seen;
  int           i0;
  int           n0;
  int           t;

  initial begin
    // No key loaded: encrypt is refused after the full payload.
    vecs[0] = '{8'h45, 1'b1, PT,   1,  {120'd0, 8'h15}, 0, 0};
    // Unknown command.
    vecs[1] = '{8'h00, 1'b0, '0,   1,  {120'd0, 8'h15}, 0, 0};
    // Key load right after the bad command: 4B must parse as a command.
    vecs[2] = '{8'h4B, 1'b1, KEY,  1,  {120'd0, 8'h06}, 1, 0};
    // Encrypt with a valid key.
    vecs[3] = '{8'h45, 1'b1, PT,   16, CT,              0, 1};

    repeat (3) @(negedge clk);
    chk("rst_s_tready", 128'(s_axis_tready), 128'(0));
    chk("rst_m_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("rst_m_tdata",  128'(m_axis_tdata),  128'(0));
    chk("rst_busy",     128'(busy),          128'(0));
    chk("rst_aes_key",  aes_key,             '0);
    chk("rst_aes_block", aes_block,          '0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      i0 = init_cnt;
      n0 = next_cnt;
      send_byte(vecs[v].cmd);
      if (vecs[v].has_payload)
        for (int i = 0; i < 16; i++) send_byte(vecs[v].payload[i*8 +: 8]);
      for (int i = 0; i < vecs[v].n_tx; i++) begin
        recv_byte(rb, rok);
        chk($sformatf("v%0d_tx%0d", v, i), {119'd0, rok, rb}, {119'd0, 1'b1, vecs[v].exp_tx[i*8 +: 8]});
      end
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_init_pulses", v), 128'(init_cnt - i0), 128'(vecs[v].exp_init));
      chk($sformatf("v%0d_next_pulses", v), 128'(next_cnt - n0), 128'(vecs[v].exp_next));
      chk($sformatf("v%0d_busy_idle", v), 128'(busy), 128'(0));
      chk($sformatf("v%0d_no_extra_tx", v), 128'(m_axis_tvalid), 128'(0));
      if (v == 2) chk("key_word", aes_key, KEY);
      if (v == 3) chk("block_word", aes_block, PT);
    end

    // Backpressure during ciphertext output, then reset mid-stream.
    m_axis_tready = 1'b0;
    send_byte(8'h45);
    for (int i = 0; i < 16; i++) send_byte(PT[i*8 +: 8]);
    t = 0;
    while (!m_axis_tvalid && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("bp_tvalid", 128'(m_axis_tvalid), 128'(1));
    hold = m_axis_tdata;
    chk("bp_first_byte", 128'(hold), 128'(8'h5a));
    stable   = 1'b1;
    rdy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_axis_tdata !== hold || m_axis_tvalid !== 1'b1) stable = 1'b0;
      if (s_axis_tready) rdy_seen = 1'b1;
    end
    chk("bp_tdata_stable", 128'(stable), 128'(1));
    chk("bp_rx_blocked",   128'(rdy_seen), 128'(0));
    chk("bp_busy",         128'(busy), 128'(1));
    m_axis_tready = 1'b1;
    @(negedge clk);
    m_axis_tready = 1'b0;
    chk("bp_second_byte", 128'(m_axis_tdata), 128'(8'hc5));
    #2 rst = 1'b1;
    #1;
    chk("arst_m_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("arst_m_tdata",  128'(m_axis_tdata),  128'(0));
    chk("arst_s_tready", 128'(s_axis_tready), 128'(0));
    chk("arst_busy",     128'(busy),          128'(0));
    chk("arst_aes_key",  aes_key,             '0);
    chk("arst_aes_block", aes_block,          '0);
    chk("arst_pulses",   128'({aes_init, aes_next}), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    m_axis_tready = 1'b1;
    @(negedge clk);

    // Key was cleared by reset: encrypt must be refused.
    n0 = next_cnt;
    send_byte(8'h45);
    for (int i = 0; i < 16; i++) send_byte(PT[i*8 +: 8]);
    recv_byte(rb, rok);
    chk("post_rst_nak", {119'd0, rok, rb}, {119'd0, 1'b1, 8'h15});
    repeat (3) @(negedge clk);
    chk("post_rst_no_next", 128'(next_cnt - n0), 128'(0));

    // Partial key frame followed by silence times out.
    i0 = init_cnt;
    send_byte(8'h4B);
    for (int i = 0; i < 5; i++) send_byte(KEY[i*8 +: 8]);
    chk("to_busy_loading", 128'(busy), 128'(1));
    recv_byte(rb, rok);
    chk("to_nak", {119'd0, rok, rb}, {119'd0, 1'b1, 8'h15});
    repeat (3) @(negedge clk);
    chk("to_no_init", 128'(init_cnt - i0), 128'(0));
    chk("to_idle",    128'(busy), 128'(0));
    chk("to_key_untouched", aes_key, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
